// File: rtl/uart_boot_loader.sv
// uart_boot_loader: receives a program image over UART (8N1) and writes it
// word-by-word into the instruction RAM. The CPU is held in reset until the
// image has been loaded.
// Frame: 0xA5, LEN (words, 0 = 2^ADDR_W), LEN*DATA_W/8 little-endian data
// bytes, then an optional checksum byte.
// Optional feature: define BOOT_CHECKSUM_EN to require and verify the
// trailing 8-bit checksum byte. When it is undefined, the loader goes to DONE
// right after the final word write.
module uart_boot_loader #(
    parameter int unsigned CLK_HZ = 25_000_000,
    parameter int unsigned BAUD   = 115_200,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_25mhz,
    input  logic              rst_n,
    input  logic              uart_rx,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              cpu_rst_n,
    output logic              boot_done,
    output logic              boot_error
);

    localparam int unsigned BIT_DIV   = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int unsigned HALF_DIV  = BIT_DIV / 2;
    localparam int unsigned CNT_W     = $clog2(BIT_DIV + 1);
    localparam int unsigned BYTES     = DATA_W / 8;
    localparam int unsigned BIDX_W    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [7:0]  SYNC_BYTE = 8'hA5;

    // ------------------------------------------------------------------
    // UART receiver
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    rx_state_t        rx_state_q, rx_state_d;
    logic             rx_meta, rx_sync, rx_prev;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_shift;
    logic             rx_valid, rx_ferr;
    logic             cnt_clr, bit_take, emit_byte, emit_ferr;
    logic [7:0]       rx_byte;

    assign rx_byte = rx_shift;

    // Two-flop synchroniser plus previous-sample register for edge detection
    always_ff @(posedge clk_25mhz) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Receiver state register
    always_ff @(posedge clk_25mhz) begin
        if (!rst_n) rx_state_q <= RX_IDLE;
        else        rx_state_q <= rx_state_d;
    end

    // Receiver next-state and sampling strobes
    always_comb begin
        rx_state_d = rx_state_q;
        cnt_clr    = 1'b0;
        bit_take   = 1'b0;
        emit_byte  = 1'b0;
        emit_ferr  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                cnt_clr = 1'b1;
                if (rx_prev && !rx_sync) rx_state_d = RX_START;
            end
            RX_START: begin
                if (rx_cnt == CNT_W'(HALF_DIV - 1)) begin
                    cnt_clr    = 1'b1;
                    // line back high at mid-start: treat as a glitch
                    rx_state_d = rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt == CNT_W'(BIT_DIV - 1)) begin
                    cnt_clr  = 1'b1;
                    bit_take = 1'b1;
                    if (rx_bit == 3'd7) rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_cnt == CNT_W'(BIT_DIV - 1)) begin
                    cnt_clr    = 1'b1;
                    emit_byte  = rx_sync;
                    emit_ferr  = !rx_sync;
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Receiver datapath: bit timer, bit index, shift register, byte strobes
    always_ff @(posedge clk_25mhz) begin
        if (!rst_n) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_valid <= emit_byte;
            rx_ferr  <= emit_ferr;
            if (cnt_clr) rx_cnt <= '0;
            else         rx_cnt <= rx_cnt + CNT_W'(1);
            if (rx_state_q == RX_IDLE) begin
                rx_bit <= '0;
            end else if (bit_take) begin
                rx_bit   <= rx_bit + 3'd1;
                rx_shift <= {rx_sync, rx_shift[7:1]};
            end
        end
    end

    // ------------------------------------------------------------------
    // Boot loader
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
`ifdef BOOT_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE,
        S_ERR
    } boot_state_t;

    boot_state_t       state_q, state_d;
    logic [ADDR_W:0]   words_left;
    logic [ADDR_W:0]   len_words;
    logic [BIDX_W-1:0] byte_idx;
    logic              last_word;
    logic              take_len, take_data, sync_seen;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    // LEN byte to word count; zero means a full 2^ADDR_W words
    always_comb begin
        len_words = '0;
        if (rx_byte == 8'h00) len_words[ADDR_W] = 1'b1;
        else                  len_words = (ADDR_W + 1)'(rx_byte);
    end

    // Loader state register
    always_ff @(posedge clk_25mhz) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Loader next-state and byte-consumption strobes
    always_comb begin
        state_d   = state_q;
        take_len  = 1'b0;
        take_data = 1'b0;
        sync_seen = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rx_valid && rx_byte == SYNC_BYTE) begin
                    sync_seen = 1'b1;
                    state_d   = S_LEN;
                end
            end
            S_LEN: begin
                if (rx_ferr) begin
                    state_d = S_ERR;
                end else if (rx_valid) begin
                    take_len = 1'b1;
                    state_d  = S_DATA;
                end
            end
            S_DATA: begin
                if (rx_ferr) begin
                    state_d = S_ERR;
                end else if (ram_we && last_word) begin
                    // leave only once the final write pulse has been issued
`ifdef BOOT_CHECKSUM_EN
                    state_d = S_CSUM;
`else
                    state_d = S_DONE;
`endif
                end else if (rx_valid) begin
                    take_data = 1'b1;
                end
            end
`ifdef BOOT_CHECKSUM_EN
            S_CSUM: begin
                if (rx_ferr) begin
                    state_d = S_ERR;
                end else if (rx_valid) begin
                    state_d = (rx_byte == csum) ? S_DONE : S_ERR;
                end
            end
`endif
            S_DONE:  state_d = S_DONE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Loader datapath: word assembly, write pulse, address, status outputs
    always_ff @(posedge clk_25mhz) begin
        if (!rst_n) begin
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            cpu_rst_n  <= 1'b0;
            boot_done  <= 1'b0;
            boot_error <= 1'b0;
            words_left <= '0;
            byte_idx   <= '0;
            last_word  <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            ram_we <= 1'b0;
            if (ram_we) ram_addr <= ram_addr + ADDR_W'(1);

            if (take_len) begin
                ram_addr   <= '0;
                byte_idx   <= '0;
                words_left <= len_words;
                last_word  <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
                csum       <= '0;
`endif
            end

            if (take_data) begin
                for (int unsigned k = 0; k < BYTES; k++) begin
                    if (byte_idx == BIDX_W'(k)) ram_wdata[8*k +: 8] <= rx_byte;
                end
`ifdef BOOT_CHECKSUM_EN
                csum <= csum + rx_byte;
`endif
                if (byte_idx == BIDX_W'(BYTES - 1)) begin
                    byte_idx   <= '0;
                    ram_we     <= 1'b1;
                    words_left <= words_left - (ADDR_W + 1)'(1);
                    if (words_left == (ADDR_W + 1)'(1)) last_word <= 1'b1;
                end else begin
                    byte_idx <= byte_idx + BIDX_W'(1);
                end
            end

            if (sync_seen) boot_error <= 1'b0;

            if (state_q == S_DONE) begin
                cpu_rst_n <= 1'b1;
                boot_done <= 1'b1;
            end

            if (state_q == S_ERR) begin
                boot_error <= 1'b1;
                cpu_rst_n  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: directed bench for uart_boot_loader. The baud rate is
// raised so one UART bit lasts 16 clocks; behaviour is otherwise unchanged.
// Honours BOOT_CHECKSUM_EN in the same way as the design.
module tb_uart_boot_loader;

    localparam int unsigned CLK_HZ  = 25_000_000;
    localparam int unsigned BAUD    = 1_562_500;
    localparam int          BIT_CYC = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        uart_rx;
    logic        ram_we;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic        cpu_rst_n;
    logic        boot_done;
    logic        boot_error;

    always #20 clk = ~clk;

    uart_boot_loader #(
        .CLK_HZ(CLK_HZ),
        .BAUD  (BAUD),
        .ADDR_W(8),
        .DATA_W(32)
    ) dut (
        .clk_25mhz (clk),
        .rst_n     (rst_n),
        .uart_rx   (uart_rx),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .cpu_rst_n (cpu_rst_n),
        .boot_done (boot_done),
        .boot_error(boot_error)
    );

    int checks = 0;
    int errors = 0;

    // every RAM write seen, plus a count of strobes wider than one cycle
    logic [7:0]  wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          we_long = 0;
    logic        we_prev = 1'b0;

    always @(negedge clk) begin
        if (ram_we) begin
            wr_addr_q.push_back(ram_addr);
            wr_data_q.push_back(ram_wdata);
        end
        if (ram_we && we_prev) we_long++;
        we_prev = ram_we;
    end

    typedef struct {
        string       name;
        int          n_junk;
        logic [7:0]  junk[3];
        logic [31:0] w0;
        logic [31:0] w1;
        logic        bad_csum;
        logic        exp_done;
        logic        exp_err;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] csum8(input logic [31:0] w0, input logic [31:0] w1);
        logic [7:0] s;
        s = 8'h00;
        for (int i = 0; i < 4; i++) s = s + w0[8*i +: 8] + w1[8*i +: 8];
        return s;
    endfunction

    task automatic send_bit(input logic b);
        uart_rx = b;
        repeat (BIT_CYC) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
        uart_rx = 1'b1;
        repeat (2 * BIT_CYC) @(posedge clk);
    endtask

    // short low pulse that must not be taken as a start bit
    task automatic send_glitch();
        uart_rx = 1'b0;
        repeat (4) @(posedge clk);
        uart_rx = 1'b1;
        repeat (2 * BIT_CYC) @(posedge clk);
    endtask

    task automatic send_frame(input logic [31:0] w0, input logic [31:0] w1,
                              input logic [7:0] cs, input logic glitch,
                              input logic with_csum);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        if (glitch) send_glitch();
        for (int i = 0; i < 4; i++) send_byte(w0[8*i +: 8], 1'b1);
        for (int i = 0; i < 4; i++) send_byte(w1[8*i +: 8], 1'b1);
        if (with_csum) send_byte(cs, 1'b1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        rst_n = 1'b1;
        @(posedge clk);
    endtask

    task automatic check_writes(input string tag, input int base,
                                input logic [31:0] w0, input logic [31:0] w1);
        check({tag, " write count"}, 32'(wr_data_q.size() - base), 32'd2);
        for (int i = 0; i < 2; i++) begin
            if (base + i < wr_data_q.size()) begin
                check({tag, " write addr"}, 32'(wr_addr_q[base + i]), 32'(i));
                check({tag, " write data"}, wr_data_q[base + i], (i == 0) ? w0 : w1);
            end else begin
                checks++;
                errors++;
                $display("FAIL %s write %0d: got no write, required addr %0d", tag, i, i);
            end
        end
    endtask

    task automatic check_status(input string tag, input logic done, input logic err);
        check({tag, " boot_done"},  32'(boot_done),  32'(done));
        check({tag, " boot_error"}, 32'(boot_error), 32'(err));
        check({tag, " cpu_rst_n"},  32'(cpu_rst_n),  32'(done));
    endtask

    initial begin
        int base;

        vecs[0] = '{"basic",  0, '{8'h00, 8'h00, 8'h00}, 32'h11223344, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{"junk",   3, '{8'h00, 8'hFF, 8'h5A}, 32'h11223344, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{"allone", 0, '{8'h00, 8'h00, 8'h00}, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0};
`ifdef BOOT_CHECKSUM_EN
        vecs[3] = '{"badsum", 0, '{8'h00, 8'h00, 8'h00}, 32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b0, 1'b1};
`else
        vecs[3] = '{"badsum", 0, '{8'h00, 8'h00, 8'h00}, 32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b1, 1'b0};
`endif

        // reset state
        uart_rx = 1'b1;
        rst_n   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_status("reset", 1'b0, 1'b0);
        check("reset ram_we",    32'(ram_we),   32'd0);
        check("reset ram_addr",  32'(ram_addr), 32'd0);
        check("reset ram_wdata", ram_wdata,     32'd0);
        rst_n = 1'b1;

        // table-driven frames
        for (int v = 0; v < 4; v++) begin
            do_reset();
            base = wr_data_q.size();
            for (int j = 0; j < vecs[v].n_junk; j++) send_byte(vecs[v].junk[j], 1'b1);
            @(negedge clk);
            check({vecs[v].name, " writes before sync"}, 32'(wr_data_q.size() - base), 32'd0);
            send_frame(vecs[v].w0, vecs[v].w1,
                       vecs[v].bad_csum ? 8'h00 : csum8(vecs[v].w0, vecs[v].w1),
                       1'b0, 1'b1);
            @(negedge clk);
            check_writes(vecs[v].name, base, vecs[v].w0, vecs[v].w1);
            check({vecs[v].name, " addr after load"}, 32'(ram_addr), 32'd2);
            check_status(vecs[v].name, vecs[v].exp_done, vecs[v].exp_err);
        end

`ifdef BOOT_CHECKSUM_EN
        // checksum error, then the correct frame resent without a reset
        do_reset();
        send_frame(32'h11223344, 32'hDEADBEEF, 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        check_status("csum err", 1'b0, 1'b1);
        base = wr_data_q.size();
        send_frame(32'h11223344, 32'hDEADBEEF, csum8(32'h11223344, 32'hDEADBEEF), 1'b0, 1'b1);
        @(negedge clk);
        check_writes("resend", base, 32'h11223344, 32'hDEADBEEF);
        check_status("resend", 1'b1, 1'b0);
`endif

        // framing error on the third data byte
        do_reset();
        base = wr_data_q.size();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h44, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h22, 1'b0);
        @(negedge clk);
        check_status("ferr", 1'b0, 1'b1);
        check("ferr writes", 32'(wr_data_q.size() - base), 32'd0);
        base = wr_data_q.size();
        send_frame(32'hCAFEF00D, 32'h0BADC0DE, csum8(32'hCAFEF00D, 32'h0BADC0DE), 1'b0, 1'b1);
        @(negedge clk);
        check_writes("after ferr", base, 32'hCAFEF00D, 32'h0BADC0DE);
        check_status("after ferr", 1'b1, 1'b0);

        // reset after five data bytes, then a full reload with a line glitch
        do_reset();
        base = wr_data_q.size();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h44, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'hEF, 1'b1);
        @(negedge clk);
        check("partial writes", 32'(wr_data_q.size() - base), 32'd1);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_status("mid reset", 1'b0, 1'b0);
        check("mid reset ram_addr",  32'(ram_addr), 32'd0);
        check("mid reset ram_wdata", ram_wdata,     32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        base = wr_data_q.size();
        send_frame(32'h11223344, 32'hDEADBEEF, 8'h00, 1'b1, 1'b0);
        @(negedge clk);
        check_writes("reload", base, 32'h11223344, 32'hDEADBEEF);
`ifdef BOOT_CHECKSUM_EN
        check_status("reload pre-csum", 1'b0, 1'b0);
`else
        check_status("reload pre-csum", 1'b1, 1'b0);
`endif
        send_byte(csum8(32'h11223344, 32'hDEADBEEF), 1'b1);
        @(negedge clk);
        check_status("reload", 1'b1, 1'b0);

        check("ram_we wider than one cycle", 32'(we_long), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
